// File: rtl/cpu_wb_seq_subtractor.sv
// cpu_wb_seq_subtractor: multi-cycle subtractor, one carry-lookahead chunk per cycle, valid/ready handshakes
module cpu_wb_seq_subtractor #(
    parameter int DATA_WID  = 32,
    parameter int CHUNK_WID = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_WID-1:0] in1,
    input  logic [DATA_WID-1:0] in2,
    input  logic                borrow_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_WID-1:0] diff,
    output logic                borrow_out,
    output logic                ovf,
    output logic                zero
);
    localparam int NCHUNK  = DATA_WID / CHUNK_WID;
    localparam int IDX_WID = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t                             state, state_nxt;
    logic [IDX_WID-1:0]                 idx;
    logic [NCHUNK-1:0][CHUNK_WID-1:0]   a_q, b_q, diff_q, diff_nxt;
    logic                               carry, last, t, acc;
    logic [CHUNK_WID-1:0]               a_k, b_k, g, p, s;
    logic [CHUNK_WID:0]                 c;
    assign last = idx == IDX_WID'(NCHUNK - 1);
    assign diff = diff_q;
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // current chunk: a + ~b + carry with every carry expanded as a flat lookahead term
    always_comb begin
        a_k  = a_q[idx];
        b_k  = ~b_q[idx];
        g    = a_k & b_k;
        p    = a_k ^ b_k;
        c    = '0;
        c[0] = carry;
        t    = 1'b0;
        acc  = 1'b0;
        for (int i = 0; i < CHUNK_WID; i++) begin
            acc = g[i];
            t   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (t & g[j]);
                t   = t & p[j];
            end
            c[i+1] = acc | (t & carry);
        end
        s             = p ^ c[CHUNK_WID-1:0];
        diff_nxt      = diff_q;
        diff_nxt[idx] = s;
    end
    // operand capture, chunk sequencing and registered result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            carry      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= in1;
            b_q   <= in2;
            carry <= ~borrow_in;
            idx   <= '0;
        end else if (state == CALC) begin
            diff_q <= diff_nxt;
            carry  <= c[CHUNK_WID];
            idx    <= last ? '0 : idx + 1'b1;
            if (last) begin
                borrow_out <= ~c[CHUNK_WID];
                ovf        <= (a_q[NCHUNK-1][CHUNK_WID-1] != b_q[NCHUNK-1][CHUNK_WID-1]) &&
                              (diff_nxt[NCHUNK-1][CHUNK_WID-1] != a_q[NCHUNK-1][CHUNK_WID-1]);
                zero       <= diff_nxt == '0;
            end
        end
    end
endmodule
